hazard_scoreboard: RTL and testbench

Pipeline hazard scoreboard for the 5-stage RISC-V core, sitting beside the ID stage. It tracks the destination registers of the instructions in EX, MEM and WB, and drives the ALU operand forwarding selects that the forwarding mux consumes one cycle later in EX. It detects load-use hazards, stalls PC and IF/ID, and injects a bubble into ID/EX. It also handles branch flush and an external whole-pipe hold.

---
 rtl/riscv_pipe_pkg.sv | 42 ++++
 rtl/rv_reg_usage_decode.sv | 54 +++++
 rtl/hazard_scoreboard.sv | 113 +++++++++++
 tb/tb_hazard_scoreboard.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared RV32I pipeline definitions: opcodes, forwarding selects and the
// scoreboard slot record, plus the forward-select rule used in ID.
package riscv_pipe_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       is_load;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '{valid: 1'b0, rd: 5'd0, is_load: 1'b0};

    // A load in EX never forwards from EX/MEM; the load-use stall covers it.
    function automatic logic [1:0] fwd_sel(input logic used, input logic [4:0] rs,
                                           input slot_t ex, input slot_t mem);
        logic [1:0] sel;
        sel = FWD_REG;
        if (used && rs != 5'd0) begin
            if (ex.valid && !ex.is_load && ex.rd == rs) begin
                sel = FWD_EXMEM;
            end else if (mem.valid && mem.rd == rs) begin
                sel = FWD_MEMWB;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/rv_reg_usage_decode.sv
// Register-usage decode of one RV32I instruction: which sources it reads,
// whether it writes rd, and whether it is a load.
module rv_reg_usage_decode
    import riscv_pipe_pkg::*;
(
    input  logic [31:0] instr,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        uses_rs1,
    output logic        uses_rs2,
    output logic        writes_rd,
    output logic        is_load
);

    logic [6:0] opcode;
    logic       wr_op;
    logic       unused_funct;

    assign opcode       = instr[6:0];
    assign rd           = instr[11:7];
    assign rs1          = instr[19:15];
    assign rs2          = instr[24:20];
    assign unused_funct = ^{instr[31:25], instr[14:12]};

    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        wr_op    = 1'b0;
        case (opcode)
            OPC_OP: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                wr_op    = 1'b1;
            end
            OPC_STORE, OPC_BRANCH: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
                uses_rs1 = 1'b1;
                wr_op    = 1'b1;
            end
            OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                wr_op = 1'b1;
            end
            default: ;
        endcase
    end

    assign writes_rd = wr_op && (rd != 5'd0);
    assign is_load   = (opcode == OPC_LOAD);

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-side hazard scoreboard: tracks rd of EX/MEM/WB, registers forwarding
// selects for EX, and raises load-use stall / bubble, flush and hold control.
module hazard_scoreboard
    import riscv_pipe_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] id_instr,
    input  logic        id_valid,
    input  logic        flush,
    input  logic        hold,
    output logic        stall_if_id,
    output logic        bubble_ex,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [31:0] stall_count
);

    logic [4:0] rs1, rs2, rd;
    logic       uses_rs1, uses_rs2, writes_rd, is_load;

    slot_t       ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic [1:0]  fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [31:0] stall_count_q, stall_count_d;

    logic       load_use;
    slot_t      id_slot;
    logic [1:0] sel_a, sel_b;
    logic       unused_wb;

    rv_reg_usage_decode u_decode (
        .instr     (id_instr),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .uses_rs1  (uses_rs1),
        .uses_rs2  (uses_rs2),
        .writes_rd (writes_rd),
        .is_load   (is_load)
    );

    // A valid EX slot always has rd != 0, so x0 sources can never match here.
    assign load_use = id_valid && ex_q.valid && ex_q.is_load &&
                      ((uses_rs1 && rs1 == ex_q.rd) || (uses_rs2 && rs2 == ex_q.rd));

    assign id_slot = '{valid: id_valid && writes_rd, rd: rd, is_load: is_load};
    assign sel_a   = id_valid ? fwd_sel(uses_rs1, rs1, ex_q, mem_q) : FWD_REG;
    assign sel_b   = id_valid ? fwd_sel(uses_rs2, rs2, ex_q, mem_q) : FWD_REG;

    always_comb begin
        ex_d          = ex_q;
        mem_d         = mem_q;
        wb_d          = wb_q;
        fwd_a_d       = fwd_a_q;
        fwd_b_d       = fwd_b_q;
        stall_count_d = stall_count_q;
        stall_if_id   = 1'b0;
        bubble_ex     = 1'b0;
        if (reset) begin
            // State is cleared by the register process; controls stay low.
        end else if (hold) begin
            stall_if_id = 1'b1;
        end else if (flush) begin
            wb_d      = mem_q;
            mem_d     = ex_q;
            ex_d      = SLOT_EMPTY;
            fwd_a_d   = FWD_REG;
            fwd_b_d   = FWD_REG;
            bubble_ex = 1'b1;
        end else if (load_use) begin
            wb_d          = mem_q;
            mem_d         = ex_q;
            ex_d          = SLOT_EMPTY;
            fwd_a_d       = FWD_REG;
            fwd_b_d       = FWD_REG;
            stall_count_d = stall_count_q + 32'd1;
            stall_if_id   = 1'b1;
            bubble_ex     = 1'b1;
        end else begin
            wb_d    = mem_q;
            mem_d   = ex_q;
            ex_d    = id_slot;
            fwd_a_d = sel_a;
            fwd_b_d = sel_b;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q          <= SLOT_EMPTY;
            mem_q         <= SLOT_EMPTY;
            wb_q          <= SLOT_EMPTY;
            fwd_a_q       <= FWD_REG;
            fwd_b_q       <= FWD_REG;
            stall_count_q <= 32'd0;
        end else begin
            ex_q          <= ex_d;
            mem_q         <= mem_d;
            wb_q          <= wb_d;
            fwd_a_q       <= fwd_a_d;
            fwd_b_q       <= fwd_b_d;
            stall_count_q <= stall_count_d;
        end
    end

    // WB is tracked for the regfile-bypass owner; nothing here consumes it yet.
    assign unused_wb = ^wb_q;

    assign fwd_a       = fwd_a_q;
    assign fwd_b       = fwd_b_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed test-plan sequences
// followed by random traffic, all checked against an in-bench pipeline model.
module tb_hazard_scoreboard;

    logic        clk;
    logic        reset;
    logic [31:0] id_instr;
    logic        id_valid;
    logic        flush;
    logic        hold;
    logic        stall_if_id;
    logic        bubble_ex;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [31:0] stall_count;

    hazard_scoreboard dut (
        .clk         (clk),
        .reset       (reset),
        .id_instr    (id_instr),
        .id_valid    (id_valid),
        .flush       (flush),
        .hold        (hold),
        .stall_if_id (stall_if_id),
        .bubble_ex   (bubble_ex),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .stall_count (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: destination register per stage (-1 = nothing written), load flag.
    int          s_rd[3];
    bit          s_ld[3];
    logic [1:0]  m_fa, m_fb;
    logic [31:0] m_cnt;
    bit          m_fwd_chk = 0;
    bit          m_regs_ok = 0;

    localparam logic [31:0] I_ADDI   = 32'h00100293;
    localparam logic [31:0] I_ADD    = 32'h00228333;
    localparam logic [31:0] I_NOP    = 32'h00000013;
    localparam logic [31:0] I_LW     = 32'h0000A283;
    localparam logic [31:0] I_ADDI0  = 32'h00100013;
    localparam logic [31:0] I_ADD00  = 32'h00000333;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Register usage straight from the RV32I opcode table.
    function automatic void classify(input logic [31:0] ins, output bit u1, output bit u2,
                                     output bit wr, output bit ld);
        u1 = 0; u2 = 0; wr = 0; ld = 0;
        case (ins[6:0])
            7'b0110011: begin u1 = 1; u2 = 1; wr = 1; end
            7'b0100011, 7'b1100011: begin u1 = 1; u2 = 1; end
            7'b0010011, 7'b1100111: begin u1 = 1; wr = 1; end
            7'b0000011: begin u1 = 1; wr = 1; ld = 1; end
            7'b0110111, 7'b0010111, 7'b1101111: wr = 1;
            default: ;
        endcase
    endfunction

    function automatic logic [1:0] exp_sel(input bit used, input int rs);
        if (!used || rs == 0) return 2'b00;
        if (s_rd[0] == rs && !s_ld[0]) return 2'b01;
        if (s_rd[1] == rs) return 2'b10;
        return 2'b00;
    endfunction

    task automatic step(input logic [31:0] ins, input logic v, input logic f,
                        input logic h, input logic r);
        bit u1, u2, wr, ld, lu;
        int rs1, rs2, rd;
        logic [1:0] sa, sb;
        logic es, eb;
        id_instr = ins; id_valid = v; flush = f; hold = h; reset = r;
        @(negedge clk);
        classify(ins, u1, u2, wr, ld);
        rd  = int'(ins[11:7]);
        rs1 = int'(ins[19:15]);
        rs2 = int'(ins[24:20]);
        lu  = v && s_rd[0] >= 0 && s_ld[0] && ((u1 && rs1 == s_rd[0]) || (u2 && rs2 == s_rd[0]));
        sa  = v ? exp_sel(u1, rs1) : 2'b00;
        sb  = v ? exp_sel(u2, rs2) : 2'b00;
        if (r)      begin es = 0; eb = 0; end
        else if (h) begin es = 1; eb = 0; end
        else if (f) begin es = 0; eb = 1; end
        else if (lu) begin es = 1; eb = 1; end
        else        begin es = 0; eb = 0; end
        check_eq("stall_if_id", 32'(stall_if_id), 32'(es));
        check_eq("bubble_ex", 32'(bubble_ex), 32'(eb));
        if (m_regs_ok) begin
            if (m_fwd_chk) begin
                check_eq("fwd_a", 32'(fwd_a), 32'(m_fa));
                check_eq("fwd_b", 32'(fwd_b), 32'(m_fb));
            end
            check_eq("stall_count", stall_count, m_cnt);
        end
        if (r) begin
            for (int i = 0; i < 3; i++) begin s_rd[i] = -1; s_ld[i] = 0; end
            m_fa = 0; m_fb = 0; m_cnt = 0; m_fwd_chk = 1; m_regs_ok = 1;
        end else if (!h) begin
            s_rd[2] = s_rd[1]; s_ld[2] = s_ld[1];
            s_rd[1] = s_rd[0]; s_ld[1] = s_ld[0];
            if (f || lu) begin
                s_rd[0] = -1; s_ld[0] = 0;
                m_fa = 0; m_fb = 0; m_fwd_chk = 1;
                if (!f) m_cnt = m_cnt + 1;
            end else begin
                s_rd[0] = (v && wr && rd != 0) ? rd : -1;
                s_ld[0] = (v && wr && rd != 0) ? ld : 0;
                m_fa = sa; m_fb = sb; m_fwd_chk = v;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(I_NOP, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    logic [6:0] opc_tab[11] = '{7'b0110011, 7'b0100011, 7'b1100011, 7'b0010011, 7'b0000011,
                                7'b1100111, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1110011,
                                7'b1111111};

    initial begin
        logic [31:0] ins;
        id_instr = '0; id_valid = 0; flush = 0; hold = 0; reset = 1;
        do_reset();
        do_reset();

        // EX/MEM forward
        step(I_ADDI, 1, 0, 0, 0);
        step(I_ADD, 1, 0, 0, 0);
        check_eq("tp1_fwd_a", 32'(fwd_a), 32'h1);
        check_eq("tp1_fwd_b", 32'(fwd_b), 32'h0);

        // MEM/WB forward across a nop
        do_reset();
        step(I_ADDI, 1, 0, 0, 0);
        step(I_NOP, 1, 0, 0, 0);
        step(I_ADD, 1, 0, 0, 0);
        check_eq("tp2_fwd_a", 32'(fwd_a), 32'h2);

        // Load-use: one stall, then MEM/WB forward on retry
        do_reset();
        step(I_LW, 1, 0, 0, 0);
        step(I_ADD, 1, 0, 0, 0);
        check_eq("tp3_cnt", stall_count, 32'd1);
        step(I_ADD, 1, 0, 0, 0);
        check_eq("tp3_fwd_a", 32'(fwd_a), 32'h2);
        check_eq("tp3_cnt2", stall_count, 32'd1);

        // Flush wins over load-use and is not counted
        do_reset();
        step(I_LW, 1, 0, 0, 0);
        step(I_ADD, 1, 1, 0, 0);
        check_eq("tp4_cnt", stall_count, 32'd0);

        // Hold for three cycles in the middle of a load-use sequence
        do_reset();
        step(I_LW, 1, 0, 0, 0);
        repeat (3) step(I_ADD, 1, 0, 1, 0);
        step(I_ADD, 1, 0, 0, 0);
        step(I_ADD, 1, 0, 0, 0);
        check_eq("tp5_cnt", stall_count, 32'd1);
        check_eq("tp5_fwd_a", 32'(fwd_a), 32'h2);

        // x0 destination never forwards
        do_reset();
        step(I_ADDI0, 1, 0, 0, 0);
        step(I_ADD00, 1, 0, 0, 0);
        check_eq("tp6_fwd_a", 32'(fwd_a), 32'h0);
        check_eq("tp6_fwd_b", 32'(fwd_b), 32'h0);

        // Reset during a stall cycle
        do_reset();
        step(I_LW, 1, 0, 0, 0);
        step(I_ADD, 1, 0, 0, 1);
        check_eq("tp7_fwd_a", 32'(fwd_a), 32'h0);
        check_eq("tp7_cnt", stall_count, 32'd0);
        step(I_ADD, 1, 0, 0, 0);

        // Random traffic over a small register window to provoke hazards
        for (int i = 0; i < 1500; i++) begin
            ins = {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   3'($urandom), 5'($urandom_range(0, 3)), opc_tab[$urandom_range(0, 10)]};
            step(ins, $urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 49) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
